// File: rtl/pipe_pkg.sv
// Shared types and constants for the two-entry skid pipeline stage:
// occupancy state encoding, default bundle widths and control-bundle bit positions.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int CTRL_W_DEF = 7;
    localparam int DATA_W_DEF = 95;
    localparam int CNT_W_DEF  = 32;

    // Control-bundle bit positions, MSB first as listed on the decoder side
    localparam int CTRL_REG_WRITE_EN = 6;
    localparam int CTRL_MEM2REG_SEL  = 5;
    localparam int CTRL_MEM_WRITE_EN = 4;
    localparam int CTRL_BRANCH       = 3;
    localparam int CTRL_ALU_CTRL     = 2;
    localparam int CTRL_ALU_SRC      = 1;
    localparam int CTRL_REG_DST_SEL  = 0;

    function automatic logic is_full(input pipe_state_e s);
        return (s == ST_FULL);
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the optional stage performance counters;
// sticks at all-ones, clears on asynchronous active-low reset.
module pipe_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline register with registered Ready_Out and flush.
// Define PIPE_STAGE_PERF_CNT_EN to add the StallCnt_Out / FlushCnt_Out counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              Valid_In,
    output logic              Ready_Out,
    input  logic [CTRL_W-1:0] Ctrl_In,
    input  logic [DATA_W-1:0] Data_In,
    input  logic              Flush_In,
    output logic              Valid_Out,
    input  logic              Ready_In,
    output logic [CTRL_W-1:0] Ctrl_Out,
    output logic [DATA_W-1:0] Data_Out
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  StallCnt_Out,
    output logic [CNT_W-1:0]  FlushCnt_Out
`endif
);

    pipe_state_e       state_q, state_d;
    logic              ready_q, ready_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic valid_out;
    logic accept;
    logic transfer;

    always_comb begin
        valid_out   = (state_q != ST_EMPTY);
        accept      = Valid_In && ready_q;
        transfer    = valid_out && Ready_In;
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        // Flush beats everything: held entries and the incoming one are dropped.
        if (Flush_In) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = Ctrl_In;
                        main_data_d = Data_In;
                    end
                end
                ST_ONE: begin
                    if (accept && transfer) begin
                        main_ctrl_d = Ctrl_In;
                        main_data_d = Data_In;
                    end else if (accept) begin
                        state_d     = ST_FULL;
                        skid_ctrl_d = Ctrl_In;
                        skid_data_d = Data_In;
                    end else if (transfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // Ready_Out is low here, so no accept can coincide.
                    if (transfer) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        ready_d = !is_full(state_d);
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_EMPTY;
            ready_q     <= 1'b1;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign Valid_Out = valid_out;
    assign Ready_Out = ready_q;
    assign Ctrl_Out  = valid_out ? main_ctrl_q : '0;
    assign Data_Out  = main_data_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
    pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (CLOCK),
        .rst_n (RESET_N),
        .inc_i (valid_out && !Ready_In),
        .cnt_o (StallCnt_Out)
    );

    pipe_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (CLOCK),
        .rst_n (RESET_N),
        .inc_i (Flush_In),
        .cnt_o (FlushCnt_Out)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the driver models stage occupancy as a
// FIFO of accepted entries; a negedge monitor checks every presented output.
module tb_pipe_stage_reg;

    localparam int CW = 7;
    localparam int DW = 95;
`ifdef PIPE_STAGE_PERF_CNT_EN
    localparam int TB_CNT_W = 4;
`else
    localparam int TB_CNT_W = 32;
`endif

    logic          CLOCK;
    logic          RESET_N;
    logic          Valid_In;
    logic          Ready_Out;
    logic [CW-1:0] Ctrl_In;
    logic [DW-1:0] Data_In;
    logic          Flush_In;
    logic          Valid_Out;
    logic          Ready_In;
    logic [CW-1:0] Ctrl_Out;
    logic [DW-1:0] Data_Out;
`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [TB_CNT_W-1:0] StallCnt_Out;
    logic [TB_CNT_W-1:0] FlushCnt_Out;
`endif

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(TB_CNT_W)) dut (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .Valid_In  (Valid_In),
        .Ready_Out (Ready_Out),
        .Ctrl_In   (Ctrl_In),
        .Data_In   (Data_In),
        .Flush_In  (Flush_In),
        .Valid_Out (Valid_Out),
        .Ready_In  (Ready_In),
        .Ctrl_Out  (Ctrl_Out),
        .Data_Out  (Data_Out)
`ifdef PIPE_STAGE_PERF_CNT_EN
        ,
        .StallCnt_Out (StallCnt_Out),
        .FlushCnt_Out (FlushCnt_Out)
`endif
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          sb[$];
    int            occ;
    int            total;
    int            bad;
    logic [DW-1:0] exp_last;
    longint        stall_m;
    longint        flush_m;
    longint        cnt_max;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: apply inputs, let the edge happen, advance the reference FIFO.
    task automatic cyc(input logic vin, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic fl, input logic rdy);
        logic acc;
        logic xf;
        Valid_In = vin;
        Ctrl_In  = c;
        Data_In  = d;
        Flush_In = fl;
        Ready_In = rdy;
        @(posedge CLOCK);
        acc = vin && (occ < 2) && !fl;
        xf  = (occ > 0) && rdy && !fl;
        if ((occ > 0) && !rdy && (stall_m < cnt_max)) stall_m++;
        if (fl && (flush_m < cnt_max)) flush_m++;
        if (fl) begin
            occ = 0;
            sb.delete();
        end else begin
            occ = occ - int'(xf) + int'(acc);
            if (acc) sb.push_back('{c: c, d: d});
        end
        #1;
    endtask

    task automatic do_reset();
        Valid_In = 1'b0;
        Flush_In = 1'b0;
        Ready_In = 1'b0;
        RESET_N  = 1'b0;
        occ      = 0;
        sb.delete();
        stall_m  = 0;
        flush_m  = 0;
        @(posedge CLOCK);
        @(posedge CLOCK);
        #1;
        RESET_N = 1'b1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // Monitor: compares presented outputs with the head of the reference FIFO.
    initial begin
        exp_last = '0;
        forever begin
            @(negedge CLOCK);
            if (!RESET_N) exp_last = '0;
            chk("valid_out", 128'(Valid_Out), 128'(occ > 0));
            chk("ready_out", 128'(Ready_Out), 128'(occ < 2));
            if (occ > 0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_empty: got occupancy %0d required 0", occ);
                end else begin
                    chk("ctrl_out", 128'(Ctrl_Out), 128'(sb[0].c));
                    chk("data_out", 128'(Data_Out), 128'(sb[0].d));
                    exp_last = sb[0].d;
                    if (Ready_In && !Flush_In) void'(sb.pop_front());
                end
            end else begin
                chk("ctrl_bubble", 128'(Ctrl_Out), 128'(0));
                chk("data_hold", 128'(Data_Out), 128'(exp_last));
            end
`ifdef PIPE_STAGE_PERF_CNT_EN
            chk("stall_cnt", 128'(StallCnt_Out), 128'(stall_m));
            chk("flush_cnt", 128'(FlushCnt_Out), 128'(flush_m));
`endif
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        occ      = 0;
        stall_m  = 0;
        flush_m  = 0;
        cnt_max  = (longint'(1) << TB_CNT_W) - 1;
        RESET_N  = 1'b0;
        Valid_In = 1'b0;
        Ctrl_In  = '0;
        Data_In  = '0;
        Flush_In = 1'b0;
        Ready_In = 1'b0;
        do_reset();

        // Passthrough: back-to-back entries with the sink always ready.
        for (int i = 1; i <= 5; i++) cyc(1'b1, 7'h55, DW'(i), 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);

        // Backpressure: A, B fill the stage, C waits until space frees.
        cyc(1'b1, 7'h0A, DW'(32'hA), 1'b0, 1'b0);
        cyc(1'b1, 7'h0B, DW'(32'hB), 1'b0, 1'b0);
        cyc(1'b1, 7'h0C, DW'(32'hC), 1'b0, 1'b0);
        cyc(1'b1, 7'h0C, DW'(32'hC), 1'b0, 1'b1);
        cyc(1'b1, 7'h0C, DW'(32'hC), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);

        // Flush while full with a new entry offered.
        cyc(1'b1, 7'h11, DW'(32'h111), 1'b0, 1'b0);
        cyc(1'b1, 7'h22, DW'(32'h222), 1'b0, 1'b0);
        cyc(1'b1, 7'h33, DW'(32'h333), 1'b1, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        cyc(1'b1, 7'h44, DW'(32'h444), 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);

        // Long stall run to push a narrow counter into saturation.
        cyc(1'b1, 7'h7F, DW'(32'h777), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);

        // Reset with entries in flight.
        cyc(1'b1, 7'h12, DW'(32'h1234), 1'b0, 1'b0);
        cyc(1'b1, 7'h34, DW'(32'h5678), 1'b0, 1'b0);
        do_reset();

        // Randomized traffic with occasional flushes and resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                do_reset();
            end else begin
                cyc(($urandom_range(0, 9) < 7), CW'($urandom), rnd_data(),
                    ($urandom_range(0, 99) < 3), ($urandom_range(0, 9) < 6));
            end
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);

        @(negedge CLOCK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
